// File: rtl/tile_config_pkg.sv
// -----------------------------------------------------------------------------
// tile_config_pkg
// Shared definitions for the tile configuration path: config bus widths, the
// per-field widths that make up one tile config word, the bitstream terminator
// and the loader state encoding. Used by the loader, the pe_tile-side config
// decoders and the bench.
// -----------------------------------------------------------------------------
package tile_config_pkg;

    localparam int BYTE_W        = 8;
    localparam int CONFIG_ADDR_W = 8;
    localparam int CLB_CFG_W     = 2;
    localparam int CB_CFG_W      = 2;
    localparam int SB_CFG_W      = 16;
    // CLB + two connection boxes + switch box = 22 bits.
    localparam int CONFIG_DATA_W = CLB_CFG_W + 2 * CB_CFG_W + SB_CFG_W;

    // Bits of the config word carried by the last frame byte; the rest of
    // that byte is pad and must be zero.
    localparam int CFG_HI_W = CONFIG_DATA_W - 2 * BYTE_W;

    localparam logic [BYTE_W-1:0] CFG_END_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_ADDR  = 3'd1,
        LD_D0    = 3'd2,
        LD_D1    = 3'd3,
        LD_D2    = 3'd4,
        LD_ISSUE = 3'd5,
        LD_DONE  = 3'd6
    } loader_state_e;

    // States in which the loader accepts a bitstream byte.
    function automatic logic is_rx_state(input loader_state_e s);
        return (s == LD_ADDR) || (s == LD_D0) || (s == LD_D1) || (s == LD_D2);
    endfunction

endpackage

// File: rtl/tile_config_loader_if.sv
// -----------------------------------------------------------------------------
// tile_config_loader_if
// Groups the loader's two buses:
//   - byte stream from the host front end: in_data / in_valid / in_ready
//   - config broadcast to the tile array: config_en / config_addr / config_data
// Modports:
//   master : the loader (consumes bytes, drives the config broadcast)
//   slave  : the environment (host front end + tile array)
// -----------------------------------------------------------------------------
interface tile_config_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 22
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              config_en;
    logic [ADDR_W-1:0] config_addr;
    logic [DATA_W-1:0] config_data;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output config_en,
        output config_addr,
        output config_data
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  config_en,
        input  config_addr,
        input  config_data
    );
endinterface

// File: rtl/tile_config_loader.sv
// -----------------------------------------------------------------------------
// tile_config_loader
// Reads a byte-stream bitstream, assembles 4-byte frames
//   addr, d[7:0], d[15:8], {pad[1:0], d[21:16]}
// and broadcasts each frame to the tile array with a one-cycle config_en.
// An address byte equal to END_ADDR ends the bitstream.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   start        begin/restart loading (honoured in IDLE or DONE only)
//   bus          byte stream in + config broadcast out (master modport)
//   busy         high in every state except IDLE and DONE
//   done         terminator received; held until start or rst
//   err          sticky pad-bit error
//   tiles_loaded config_en pulses since the last start (saturating)
// -----------------------------------------------------------------------------
module tile_config_loader
    import tile_config_pkg::*;
#(
    parameter int                ADDR_W   = CONFIG_ADDR_W,
    parameter int                DATA_W   = CONFIG_DATA_W,
    parameter logic [BYTE_W-1:0] END_ADDR = CFG_END_ADDR,
    parameter int                COUNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    tile_config_loader_if.master  bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [COUNT_W-1:0]    tiles_loaded
);

    loader_state_e r_state;
    loader_state_e w_state_nxt;

    logic               r_in_ready;
    logic               r_config_en;
    logic [ADDR_W-1:0]  r_config_addr;
    logic [DATA_W-1:0]  r_config_data;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [COUNT_W-1:0] r_tiles_loaded;

    logic [ADDR_W-1:0]  r_addr_hold;
    logic [BYTE_W-1:0]  r_d0_hold;
    logic [BYTE_W-1:0]  r_d1_hold;

    logic               w_in_ready_nxt;
    logic               w_busy_nxt;
    logic               w_config_en_nxt;
    logic               w_done_nxt;
    logic               w_xfer;
    logic               w_restart;
    logic               w_pad_bad;
    logic [DATA_W-1:0]  w_word;

    assign w_xfer    = bus.in_valid && r_in_ready;
    assign w_restart = (r_state == LD_DONE) && start;
    assign w_pad_bad = (bus.in_data[BYTE_W-1:CFG_HI_W] != '0);
    // The last byte is still on the bus when the frame completes, so the word
    // is formed from it directly and the config registers load on that edge,
    // putting word and strobe on the bus together during ISSUE.
    assign w_word    = DATA_W'({bus.in_data[CFG_HI_W-1:0], r_d1_hold, r_d0_hold});

    // ---------------------------------------------------------------- state reg
    // NOTE: every clocked process uses non-blocking (<=) assignments so all
    // registers sample pre-edge values; blocking here would create order-
    // dependent simulation and a mismatch with synthesis.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        // NOTE: default assignment first so no path leaves w_state_nxt
        // unassigned, which would infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            LD_IDLE:  if (start) w_state_nxt = LD_ADDR;
            LD_ADDR:  if (w_xfer) w_state_nxt = (bus.in_data == END_ADDR) ? LD_DONE : LD_D0;
            LD_D0:    if (w_xfer) w_state_nxt = LD_D1;
            LD_D1:    if (w_xfer) w_state_nxt = LD_D2;
            LD_D2:    if (w_xfer) w_state_nxt = LD_ISSUE;
            LD_ISSUE: w_state_nxt = LD_ADDR;
            LD_DONE:  if (start) w_state_nxt = LD_ADDR;
            default:  w_state_nxt = LD_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Outputs are decoded from the next state and registered, so each one is a
    // clean flop output aligned with the state it describes.
    always_comb begin
        w_in_ready_nxt  = is_rx_state(w_state_nxt);
        w_busy_nxt      = (w_state_nxt != LD_IDLE) && (w_state_nxt != LD_DONE);
        w_config_en_nxt = (w_state_nxt == LD_ISSUE);
        w_done_nxt      = (w_state_nxt == LD_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready     <= 1'b0;
            r_config_en    <= 1'b0;
            r_config_addr  <= '0;
            r_config_data  <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_tiles_loaded <= '0;
        end else begin
            r_in_ready  <= w_in_ready_nxt;
            r_config_en <= w_config_en_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;

            // Config bus only changes when a frame completes; it holds the
            // last issued frame while the next one is assembled.
            if ((r_state == LD_D2) && w_xfer) begin
                r_config_addr <= r_addr_hold;
                r_config_data <= w_word;
            end

            if (w_restart) begin
                r_err <= 1'b0;
            end else if ((r_state == LD_D2) && w_xfer && w_pad_bad) begin
                r_err <= 1'b1;
            end

            if (w_restart) begin
                r_tiles_loaded <= '0;
            end else if (w_config_en_nxt && (r_tiles_loaded != '1)) begin
                r_tiles_loaded <= r_tiles_loaded + COUNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------- frame assembly
    // NOTE: the holding registers carry no reset; each is written before the
    // frame that uses it can complete, so its reset value is never observed.
    always_ff @(posedge clk) begin
        if (w_xfer) begin
            case (r_state)
                LD_ADDR: r_addr_hold <= ADDR_W'(bus.in_data);
                LD_D0:   r_d0_hold   <= bus.in_data;
                LD_D1:   r_d1_hold   <= bus.in_data;
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = r_in_ready;
    assign bus.config_en   = r_config_en;
    assign bus.config_addr = r_config_addr;
    assign bus.config_data = r_config_data;
    assign busy            = r_busy;
    assign done            = r_done;
    assign err             = r_err;
    assign tiles_loaded    = r_tiles_loaded;

endmodule

// File: tb/tb_tile_config_loader.sv
// -----------------------------------------------------------------------------
// tb_tile_config_loader
// Directed bench for tile_config_loader: single frame, back-to-back frames,
// stalled byte stream, pad error, reset mid-frame, empty bitstream + restart.
// -----------------------------------------------------------------------------
module tb_tile_config_loader;
    import tile_config_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] tiles_loaded;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;

    typedef struct {
        logic [7:0]  addr;
        logic [21:0] data;
        int          cyc;
    } pulse_t;

    pulse_t pq[$];

    tile_config_loader_if #(.ADDR_W(8), .DATA_W(22)) bus ();

    tile_config_loader #(
        .ADDR_W  (8),
        .DATA_W  (22),
        .END_ADDR(8'hFF),
        .COUNT_W (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .tiles_loaded(tiles_loaded)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Record every config_en cycle; no byte may be accepted while it is high.
    always @(negedge clk) begin
        if (bus.config_en === 1'b1) begin
            pq.push_back('{addr: bus.config_addr, data: bus.config_data, cyc: cyc});
            check("rdy_in_issue", {31'd0, bus.in_ready}, 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        bus.in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("xfer_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b0,
                              input logic [7:0] b1, input logic [7:0] b2);
        send_byte(a, 0);
        send_byte(b0, 0);
        send_byte(b1, 0);
        send_byte(b2, 0);
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // ---------------------------------------------------------- reset state
        do_reset();
        check("rst_in_ready", {31'd0, bus.in_ready},  32'd0);
        check("rst_cfg_en",   {31'd0, bus.config_en}, 32'd0);
        check("rst_cfg_addr", {24'd0, bus.config_addr}, 32'd0);
        check("rst_cfg_data", {10'd0, bus.config_data}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check("rst_done",     {31'd0, done}, 32'd0);
        check("rst_err",      {31'd0, err},  32'd0);
        check("rst_tiles",    {24'd0, tiles_loaded}, 32'd0);

        // --------------------------------------------------------- single frame
        pulse_start();
        check("sf_busy",     {31'd0, busy}, 32'd1);
        check("sf_in_ready", {31'd0, bus.in_ready}, 32'd1);
        send_frame(8'h05, 8'h34, 8'h12, 8'h2A);
        send_byte(8'hFF, 0);
        check("sf_pulses", pq.size(), 32'd1);
        if (pq.size() > 0) begin
            check("sf_addr", {24'd0, pq[0].addr}, 32'h05);
            check("sf_data", {10'd0, pq[0].data}, 32'h2A1234);
        end
        check("sf_done",  {31'd0, done}, 32'd1);
        check("sf_busy0", {31'd0, busy}, 32'd0);
        check("sf_tiles", {24'd0, tiles_loaded}, 32'd1);
        check("sf_err",   {31'd0, err},  32'd0);
        check("sf_hold_data", {10'd0, bus.config_data}, 32'h2A1234);
        pq.delete();

        // ---------------------------------------------------- back-to-back frames
        pulse_start();
        check("bb_done_clr", {31'd0, done}, 32'd0);
        send_frame(8'h00, 8'h11, 8'h22, 8'h33);
        send_frame(8'h01, 8'hAA, 8'hBB, 8'h3C);
        send_frame(8'h02, 8'hFF, 8'hFF, 8'h3F);
        send_byte(8'hFF, 0);
        check("bb_pulses", pq.size(), 32'd3);
        if (pq.size() == 3) begin
            check("bb_addr0", {24'd0, pq[0].addr}, 32'h00);
            check("bb_data0", {10'd0, pq[0].data}, 32'h332211);
            check("bb_addr1", {24'd0, pq[1].addr}, 32'h01);
            check("bb_data1", {10'd0, pq[1].data}, 32'h3CBBAA);
            check("bb_addr2", {24'd0, pq[2].addr}, 32'h02);
            check("bb_data2", {10'd0, pq[2].data}, 32'h3FFFFF);
            check("bb_gap01", pq[1].cyc - pq[0].cyc, 32'd5);
            check("bb_gap12", pq[2].cyc - pq[1].cyc, 32'd5);
        end
        check("bb_tiles", {24'd0, tiles_loaded}, 32'd3);
        check("bb_hold_addr", {24'd0, bus.config_addr}, 32'h02);
        pq.delete();

        // ------------------------------------------- stalls + ignored mid-frame start
        pulse_start();
        send_byte(8'h05, 3);
        send_byte(8'h34, 0);
        pulse_start();                 // lands in D1: must be ignored
        send_byte(8'h12, 7);
        check("st_no_early", pq.size(), 32'd0);
        send_byte(8'h2A, 5);
        send_byte(8'hFF, 2);
        check("st_pulses", pq.size(), 32'd1);
        if (pq.size() > 0) begin
            check("st_addr", {24'd0, pq[0].addr}, 32'h05);
            check("st_data", {10'd0, pq[0].data}, 32'h2A1234);
        end
        check("st_done",  {31'd0, done}, 32'd1);
        check("st_tiles", {24'd0, tiles_loaded}, 32'd1);
        pq.delete();

        // ------------------------------------------------------------ pad error
        pulse_start();
        send_frame(8'h10, 8'h78, 8'h56, 8'hC1);
        check("pe_err_set", {31'd0, err}, 32'd1);
        send_byte(8'hFF, 0);
        check("pe_pulses", pq.size(), 32'd1);
        if (pq.size() > 0) begin
            check("pe_addr", {24'd0, pq[0].addr}, 32'h10);
            check("pe_data", {10'd0, pq[0].data}, 32'h015678);
        end
        check("pe_err_done", {31'd0, err},  32'd1);
        check("pe_done",     {31'd0, done}, 32'd1);
        pq.delete();
        pulse_start();
        check("pe_err_clr",   {31'd0, err},  32'd0);
        check("pe_done_clr",  {31'd0, done}, 32'd0);
        check("pe_tiles_clr", {24'd0, tiles_loaded}, 32'd0);

        // ----------------------------------------------------- reset mid-frame
        send_byte(8'h20, 0);
        send_byte(8'h44, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rm_pulses",   pq.size(), 32'd0);
        check("rm_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check("rm_busy",     {31'd0, busy}, 32'd0);
        check("rm_cfg_addr", {24'd0, bus.config_addr}, 32'd0);
        check("rm_cfg_data", {10'd0, bus.config_data}, 32'd0);
        check("rm_done",     {31'd0, done}, 32'd0);
        check("rm_tiles",    {24'd0, tiles_loaded}, 32'd0);
        pulse_start();
        send_frame(8'h21, 8'h01, 8'h02, 8'h03);
        send_byte(8'hFF, 0);
        check("rm_pulses2", pq.size(), 32'd1);
        if (pq.size() > 0) begin
            check("rm_addr", {24'd0, pq[0].addr}, 32'h21);
            check("rm_data", {10'd0, pq[0].data}, 32'h030201);
        end
        check("rm_tiles2", {24'd0, tiles_loaded}, 32'd1);
        pq.delete();

        // ------------------------------------------ empty bitstream and restart
        do_reset();
        pulse_start();
        send_byte(8'hFF, 0);
        check("em_done",   {31'd0, done}, 32'd1);
        check("em_tiles",  {24'd0, tiles_loaded}, 32'd0);
        check("em_pulses", pq.size(), 32'd0);
        pulse_start();
        check("em_done_clr", {31'd0, done}, 32'd0);
        check("em_busy",     {31'd0, busy}, 32'd1);
        send_frame(8'h7E, 8'hEF, 8'hBE, 8'h2D);
        send_byte(8'hFF, 0);
        check("em_pulses2", pq.size(), 32'd1);
        if (pq.size() > 0) begin
            check("em_addr", {24'd0, pq[0].addr}, 32'h7E);
            check("em_data", {10'd0, pq[0].data}, 32'h2DBEEF);
        end
        check("em_tiles2", {24'd0, tiles_loaded}, 32'd1);
        check("em_done2",  {31'd0, done}, 32'd1);
        pq.delete();

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_config_loader.md
Name: tile_config_loader

Overview:
- Sequencer that configures the tile array from a byte-stream bitstream.
- Accepts bytes from a host front end (e.g. SPI/UART receiver) over a valid/ready handshake.
- Assembles each frame (tile address + 22-bit config word) and issues a one-cycle config_en broadcast on the shared config_addr/config_data bus that every pe_tile decodes.
- Reports progress and done/error status to the top level.

Parameters:
- ADDR_W, 8, width of the tile config address bus.
- DATA_W, 22, config word width: CLB 2 + CB 2 + CB 2 + SB 16.
- END_ADDR, 8'hFF, address byte that terminates the bitstream; never a valid tile address.
- COUNT_W, 8, width of the tiles_loaded counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin or restart loading; honoured only in IDLE or DONE.
- in_data  in  8  bitstream byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a byte this cycle.
- config_en  out  1  one-cycle write strobe to the tile array.
- config_addr  out  ADDR_W  target tile address.
- config_data  out  DATA_W  config word.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  END_ADDR received; held until start or rst.
- err  out  1  sticky format error.
- tiles_loaded  out  COUNT_W  config_en pulses issued since the last start.

Behaviour:
- Reset is synchronous and active-high. One clock domain, clk.
- Reset values: state=IDLE, in_ready=0, config_en=0, config_addr=0, config_data=0, busy=0, done=0, err=0, tiles_loaded=0.
- A byte transfer occurs on a cycle with in_valid && in_ready. The loader never drops or duplicates a byte. in_valid while in_ready=0 is ignored.
- Frame format, 4 bytes, in order:
  - addr
  - d[7:0]
  - d[15:8]
  - {pad[1:0], d[21:16]}
- States:
  - IDLE: in_ready=0. start -> ADDR.
  - ADDR: in_ready=1. On transfer: byte==END_ADDR -> DONE, setting done=1 on the entry edge. Otherwise latch the byte into an address holding register -> D0.
  - D0: in_ready=1. On transfer, latch d[7:0] -> D1.
  - D1: in_ready=1. On transfer, latch d[15:8] -> D2.
  - D2: in_ready=1. On transfer, latch d[21:16]. If pad!=0, set err; the frame is still issued. -> ISSUE.
  - ISSUE: in_ready=0. Drive config_en=1 for exactly this one cycle, with config_addr/config_data driven from the holding registers the same cycle. tiles_loaded increments, saturating at all-ones. -> ADDR.
  - DONE: in_ready=0. start -> ADDR, and on the same edge clear done, err and tiles_loaded.
- All outputs are registered. config_en is never high outside ISSUE.
- config_addr/config_data retain their last issued values after ISSUE. They are not updated while a frame is being assembled.
- Minimum throughput: 5 cycles per frame (4 transfers + ISSUE). There is no cap on stall length between bytes.
- start in ADDR/D0/D1/D2/ISSUE is ignored.
- An empty bitstream (first byte END_ADDR) goes straight to DONE with tiles_loaded=0.
- rst mid-frame: the partial frame is discarded, state -> IDLE, and no config_en is issued. If rst coincides with ISSUE, the config_en is suppressed on the next cycle.
- Address 0 is a legal tile address.

Decomposition:
- Shared package/header tile_config_pkg holds: CONFIG_ADDR_W=8, CLB_CFG_W=2, CB_CFG_W=2, SB_CFG_W=16, CONFIG_DATA_W (sum = 22), CFG_END_ADDR=8'hFF, and the loader state encoding.
- The package is reused by pe_tile-side config decoders and by the bench.
- Single module; no sub-module is warranted. The byte assembler is inlined with the FSM.

Test Plan:
- Single frame: rst, start, bytes 0x05,0x34,0x12,0x2A,0xFF with continuous in_valid -> exactly one config_en cycle with config_addr=0x05, config_data=22'h2A1234; then done=1, tiles_loaded=1, err=0.
- Back-to-back frames: three frames (addr 0x00, 0x01, 0x02) then 0xFF -> three config_en pulses 5 cycles apart, correct words in order, tiles_loaded=3.
- Stalls: random in_valid gaps of 0–7 cycles during a frame -> issued word identical to the no-stall case; in_ready low during ISSUE, so no byte is consumed there.
- Pad error: last data byte 0xC1 -> config_data[21:16]=6'h01, config_en still issued, err=1 held through DONE; a subsequent start clears err.
- Reset mid-frame: rst asserted after the d[7:0] byte -> no config_en, state IDLE, all outputs at reset values; next start loads a fresh frame correctly.
- Empty bitstream and restart: start, 0xFF -> done=1, tiles_loaded=0. Then start in DONE with one frame -> done clears on that edge and tiles_loaded=1 at the end.
